// File: rtl/apb_timer_if.sv
// APB bus bundle between the NMI bridge (master) and the timer (slave).
// Only the signals the timer consumes; there is no pslverr.
interface apb_timer_if #(
    parameter int ADDR_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic              pready;
    logic [ADDR_W-1:0] paddr;
    logic [31:0]       pwdata;
    logic [3:0]        pstrb;
    logic [31:0]       prdata;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, pstrb,
        input  pready, prdata
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, pstrb,
        output pready, prdata
    );
endinterface

// File: rtl/apb_timer.sv
// APB timer: prescaled 32-bit up-counter with compare match,
// optional auto-reload, level interrupt and access wait states.
module apb_timer #(
    parameter int ADDR_W      = 32,
    parameter int PRESC_W     = 16,
    parameter int WAIT_CYCLES = 0
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    apb_timer_if.slave apb,
    output logic       irq_o
);
    localparam int WW = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    logic [2:0]         sel;
    logic               access;
    logic               wr;
    logic [WW-1:0]      wcnt_q;
    logic [2:0]         ctrl_q;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] pcnt_q;
    logic [31:0]        count_q;
    logic [31:0]        cmp_q;
    logic               match_q;
    logic [31:0]        reg_val;
    logic [31:0]        wdata_m;
    logic               en;
    logic               tick;
    logic               hit;
    logic               wr_ctrl;
    logic               wr_presc;
    logic               wr_count;
    logic               wr_cmp;
    logic               w1c_match;
    logic               unused_addr;

    assign sel         = apb.paddr[4:2];
    assign unused_addr = ^{apb.paddr[ADDR_W-1:5], apb.paddr[1:0]};

    // Gated by reset so pready drops at once even if the master keeps psel up.
    assign access     = rst_ni & apb.psel & apb.penable;
    assign apb.pready = access & (wcnt_q == WW'(WAIT_CYCLES));
    assign wr         = apb.pready & apb.pwrite;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wcnt_q <= '0;
        end else if (!apb.psel || apb.pready) begin
            wcnt_q <= '0;
        end else if (access) begin
            wcnt_q <= wcnt_q + 1'b1;
        end
    end

    always_comb begin
        reg_val = '0;
        case (sel)
            3'd0:    reg_val = {29'd0, ctrl_q};
            3'd1:    reg_val = 32'(presc_q);
            3'd2:    reg_val = count_q;
            3'd3:    reg_val = cmp_q;
            3'd4:    reg_val = {31'd0, match_q};
            default: reg_val = '0;
        endcase
    end

    assign apb.prdata = (access && !apb.pwrite) ? reg_val : '0;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
        end
        return r;
    endfunction

    assign wdata_m   = merge(reg_val, apb.pwdata, apb.pstrb);
    assign wr_ctrl   = wr && (sel == 3'd0);
    assign wr_presc  = wr && (sel == 3'd1);
    assign wr_count  = wr && (sel == 3'd2);
    assign wr_cmp    = wr && (sel == 3'd3);
    assign w1c_match = wr && (sel == 3'd4) && apb.pstrb[0] && apb.pwdata[0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_q  <= '0;
            presc_q <= '0;
            cmp_q   <= '1;
        end else begin
            if (wr_ctrl)  ctrl_q  <= wdata_m[2:0];
            if (wr_presc) presc_q <= wdata_m[PRESC_W-1:0];
            if (wr_cmp)   cmp_q   <= wdata_m;
        end
    end

    assign en   = ctrl_q[0];
    assign tick = en && (pcnt_q == presc_q);
    assign hit  = (count_q == cmp_q);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pcnt_q <= '0;
        end else if (!en || wr_presc || tick) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_q + 1'b1;
        end
    end

    // A bus write to COUNT overrides the tick update in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
        end else if (wr_count) begin
            count_q <= wdata_m;
        end else if (tick) begin
            count_q <= (hit && ctrl_q[1]) ? 32'd0 : count_q + 32'd1;
        end
    end

    // Set has priority over a concurrent write-1-to-clear.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q <= 1'b0;
        end else if (tick && hit) begin
            match_q <= 1'b1;
        end else if (w1c_match) begin
            match_q <= 1'b0;
        end
    end

    assign irq_o = match_q & ctrl_q[2];
endmodule

// File: tb/tb_apb_timer.sv
// Directed bench for apb_timer: zero-wait instance for most scenarios,
// a second instance with two wait states for the handshake timing.
module tb_apb_timer;
    logic clk;
    logic rst_n;
    logic irq0;
    logic irq2;
    int   total;
    int   bad;

    apb_timer_if #(.ADDR_W(32)) b0 ();
    apb_timer_if #(.ADDR_W(32)) b2 ();

    apb_timer #(.ADDR_W(32), .PRESC_W(16), .WAIT_CYCLES(0)) dut0 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .apb    (b0),
        .irq_o  (irq0)
    );

    apb_timer #(.ADDR_W(32), .PRESC_W(16), .WAIT_CYCLES(2)) dut2 (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .apb    (b2),
        .irq_o  (irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic apb_write(input logic [31:0] addr,
                             input logic [31:0] data,
                             input logic [3:0]  strb);
        int n;
        @(posedge clk); #1;
        b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
        b0.paddr = addr; b0.pwdata = data; b0.pstrb = strb;
        @(posedge clk); #1;
        b0.penable = 1'b1;
        #1;
        n = 0;
        while (!b0.pready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!b0.pready) begin
            total++; bad++;
            $display("FAIL wr_pready_timeout addr=%h got=0 want=1", addr);
        end
        @(posedge clk); #1;
        b0.psel = 1'b0; b0.penable = 1'b0; b0.pwrite = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
        int n;
        @(posedge clk); #1;
        b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b0;
        b0.paddr = addr; b0.pstrb = 4'h0;
        @(posedge clk); #1;
        b0.penable = 1'b1;
        #1;
        n = 0;
        while (!b0.pready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!b0.pready) begin
            total++; bad++;
            $display("FAIL rd_pready_timeout addr=%h got=0 want=1", addr);
        end
        data = b0.prdata;
        @(posedge clk); #1;
        b0.psel = 1'b0; b0.penable = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        apb_write(32'h04, 32'd0, 4'hF);
        apb_write(32'h0C, 32'd2, 4'hF);
        apb_write(32'h00, 32'h5, 4'hF);
        repeat (6) @(posedge clk);
        #1;
        total++;
        if (irq0 !== 1'b1) begin
            bad++; $display("FAIL pre_reset_irq got=%b want=1", irq0);
        end
        // start a COUNT write and kill it with reset during its access phase
        b0.psel = 1'b1; b0.penable = 1'b0; b0.pwrite = 1'b1;
        b0.paddr = 32'h08; b0.pwdata = 32'h55; b0.pstrb = 4'hF;
        @(posedge clk); #1;
        b0.penable = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (irq0 !== 1'b0) begin
            bad++; $display("FAIL reset_irq got=%b want=0", irq0);
        end
        total++;
        if (b0.pready !== 1'b0) begin
            bad++; $display("FAIL reset_pready got=%b want=0", b0.pready);
        end
        b0.psel = 1'b0; b0.penable = 1'b0; b0.pwrite = 1'b0;
        @(posedge clk); #4;
        rst_n = 1'b1;
        apb_read(32'h00, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reset_ctrl got=%h want=00000000", d);
        end
        apb_read(32'h08, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reset_count got=%h want=00000000", d);
        end
        apb_read(32'h0C, d);
        total++;
        if (d !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL reset_cmp got=%h want=ffffffff", d);
        end
        apb_read(32'h10, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reset_status got=%h want=00000000", d);
        end
    endtask

    task automatic test_strobe();
        logic [31:0] d;
        apb_write(32'h0C, 32'hAABB_CCDD, 4'b0010);
        apb_read(32'h0C, d);
        total++;
        if (d !== 32'hFFFF_CCFF) begin
            bad++; $display("FAIL strobe_cmp got=%h want=ffffccff", d);
        end
        apb_read(32'h14, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL raz_hole got=%h want=00000000", d);
        end
    endtask

    task automatic test_match_irq();
        logic [31:0] d;
        apb_write(32'h04, 32'd3, 4'hF);
        apb_write(32'h0C, 32'd9, 4'hF);
        apb_write(32'h00, 32'h7, 4'hF);
        repeat (39) @(posedge clk);
        #1;
        total++;
        if (irq0 !== 1'b0) begin
            bad++; $display("FAIL irq_early got=%b want=0", irq0);
        end
        @(posedge clk); #1;
        total++;
        if (irq0 !== 1'b1) begin
            bad++; $display("FAIL irq_at_40 got=%b want=1", irq0);
        end
        apb_read(32'h08, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL reload_count got=%h want=00000000", d);
        end
        apb_read(32'h10, d);
        total++;
        if (d !== 32'h1) begin
            bad++; $display("FAIL match_status got=%h want=00000001", d);
        end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        apb_write(32'h00, 32'h0, 4'hF);
        apb_write(32'h10, 32'h1, 4'hF);
        apb_read(32'h10, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL w1c_plain got=%h want=00000000", d);
        end
        // CMP=0 with auto-reload and PRESC=0 matches on every cycle
        apb_write(32'h04, 32'd0, 4'hF);
        apb_write(32'h08, 32'd0, 4'hF);
        apb_write(32'h0C, 32'd0, 4'hF);
        apb_write(32'h00, 32'h7, 4'hF);
        apb_write(32'h10, 32'h1, 4'hF);
        total++;
        if (irq0 !== 1'b1) begin
            bad++; $display("FAIL race_irq got=%b want=1", irq0);
        end
        apb_read(32'h10, d);
        total++;
        if (d !== 32'h1) begin
            bad++; $display("FAIL race_status got=%h want=00000001", d);
        end
        apb_write(32'h00, 32'h4, 4'hF);
        apb_write(32'h10, 32'h1, 4'hF);
        total++;
        if (irq0 !== 1'b0) begin
            bad++; $display("FAIL later_w1c_irq got=%b want=0", irq0);
        end
        apb_read(32'h10, d);
        total++;
        if (d !== 32'h0) begin
            bad++; $display("FAIL later_w1c_status got=%h want=00000000", d);
        end
    endtask

    task automatic test_wait_states();
        @(posedge clk); #1;
        b2.psel = 1'b1; b2.penable = 1'b0; b2.pwrite = 1'b1;
        b2.paddr = 32'h08; b2.pwdata = 32'd5; b2.pstrb = 4'hF;
        #1;
        total++;
        if (b2.pready !== 1'b0) begin
            bad++; $display("FAIL ws_setup_pready got=%b want=0", b2.pready);
        end
        @(posedge clk); #1;
        b2.penable = 1'b1;
        #1;
        total++;
        if (b2.pready !== 1'b0) begin
            bad++; $display("FAIL ws_cycle1_pready got=%b want=0", b2.pready);
        end
        @(posedge clk); #1;
        total++;
        if (b2.pready !== 1'b0) begin
            bad++; $display("FAIL ws_cycle2_pready got=%b want=0", b2.pready);
        end
        total++;
        if (dut2.count_q !== 32'd0) begin
            bad++; $display("FAIL ws_cycle2_count got=%h want=00000000", dut2.count_q);
        end
        @(posedge clk); #1;
        total++;
        if (b2.pready !== 1'b1) begin
            bad++; $display("FAIL ws_cycle3_pready got=%b want=1", b2.pready);
        end
        total++;
        if (dut2.count_q !== 32'd0) begin
            bad++; $display("FAIL ws_cycle3_count got=%h want=00000000", dut2.count_q);
        end
        @(posedge clk); #1;
        total++;
        if (dut2.count_q !== 32'd5) begin
            bad++; $display("FAIL ws_commit_count got=%h want=00000005", dut2.count_q);
        end
        b2.psel = 1'b0; b2.penable = 1'b0; b2.pwrite = 1'b0;
        #1;
        total++;
        if (b2.pready !== 1'b0) begin
            bad++; $display("FAIL ws_idle_pready got=%b want=0", b2.pready);
        end
    endtask

    task automatic test_wrap();
        apb_write(32'h04, 32'd0, 4'hF);
        apb_write(32'h0C, 32'd0, 4'hF);
        apb_write(32'h08, 32'hFFFF_FFFE, 4'hF);
        apb_write(32'h10, 32'h1, 4'hF);
        apb_write(32'h00, 32'h1, 4'hF);
        @(posedge clk); #1;
        total++;
        if (dut0.count_q !== 32'hFFFF_FFFF) begin
            bad++; $display("FAIL wrap_t1 got=%h want=ffffffff", dut0.count_q);
        end
        @(posedge clk); #1;
        total++;
        if (dut0.count_q !== 32'h0 || dut0.match_q !== 1'b0) begin
            bad++;
            $display("FAIL wrap_t2 got=%h/%b want=00000000/0", dut0.count_q, dut0.match_q);
        end
        @(posedge clk); #1;
        total++;
        if (dut0.count_q !== 32'h1 || dut0.match_q !== 1'b1) begin
            bad++;
            $display("FAIL wrap_t3 got=%h/%b want=00000001/1", dut0.count_q, dut0.match_q);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        b0.psel = 1'b0; b0.penable = 1'b0; b0.pwrite = 1'b0;
        b0.paddr = '0; b0.pwdata = '0; b0.pstrb = '0;
        b2.psel = 1'b0; b2.penable = 1'b0; b2.pwrite = 1'b0;
        b2.paddr = '0; b2.pwdata = '0; b2.pstrb = '0;
        repeat (3) @(posedge clk);
        #4;
        rst_n = 1'b1;
        test_reset();
        test_strobe();
        test_match_irq();
        test_w1c_race();
        test_wait_states();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
